// File: rtl/cache_reader_pkg.sv
// Shared definitions for the cache_reader read sequencer: default widths,
// cache depth and the sequencer state encoding.
package cache_reader_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 3;
    localparam int DEF_CNT_W   = 4;
    localparam int CACHE_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cache_reader_pairbuf.sv
// Two-entry capture/drain buffer: loads one or two cache words in a single
// cycle and presents them one at a time with a stall-stable registered output.
module cache_reader_pairbuf
    import cache_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_two,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              last_pop
);

    logic [DATA_W-1:0] buf0_r;
    logic [DATA_W-1:0] buf1_r;
    logic              v0_r;
    logic              v1_r;

    // Capture on load, shift buf1 forward on each accepted sample, hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf0_r <= '0;
            buf1_r <= '0;
            v0_r   <= 1'b0;
            v1_r   <= 1'b0;
        end else if (load) begin
            buf0_r <= din0;
            v0_r   <= 1'b1;
            if (load_two) begin
                buf1_r <= din1;
                v1_r   <= 1'b1;
            end else begin
                buf1_r <= buf1_r;
                v1_r   <= 1'b0;
            end
        end else if (pop) begin
            buf0_r <= v1_r ? buf1_r : buf0_r;
            v0_r   <= v1_r;
            buf1_r <= buf1_r;
            v1_r   <= 1'b0;
        end else begin
            buf0_r <= buf0_r;
            buf1_r <= buf1_r;
            v0_r   <= v0_r;
            v1_r   <= v1_r;
        end
    end

    assign out_valid = v0_r;
    assign out_data  = buf0_r;
    assign last_pop  = pop && !v1_r;

endmodule

// File: rtl/cache_reader.sv
// Read-side sequencer for the 8-entry sample cache: fetches entry pairs through
// ports A/B and streams them on valid/ready. Optional running checksum of the
// streamed samples is enabled by defining CACHE_READER_CHECKSUM_EN.
module cache_reader
    import cache_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_SEND  = SEND;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(CACHE_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_TWO = CNT_W'(2);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_TWO = ADDR_W'(2);

    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_s;
    logic [CNT_W-1:0]  rem_r;
    logic [CNT_W-1:0]  rem_s;
    logic              busy_r;
    logic              done_r;
    logic              fetch_s;
    logic              take_two_s;
    logic              start_ok_s;
    logic              pop_s;
    logic              last_pop_s;

    assign pop_s  = out_valid && out_ready;
    assign addr_a = ptr_r;
    assign addr_b = ptr_r + PTR_ONE;

    // Sequencer next-state, pointer and remaining-count logic.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        rem_s      = rem_r;
        fetch_s    = 1'b0;
        take_two_s = 1'b0;
        start_ok_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_ok_s = 1'b1;
                    if (count == '0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FETCH;
                        ptr_s   = base_addr;
                        rem_s   = (count > MAX_CNT) ? MAX_CNT : count;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                fetch_s    = 1'b1;
                take_two_s = (rem_r >= CNT_TWO);
                rem_s      = take_two_s ? (rem_r - CNT_TWO) : (rem_r - CNT_ONE);
                ptr_s      = ptr_r + PTR_TWO;
                state_s    = ST_SEND;
            end
            ST_SEND: begin
                if (last_pop_s) begin
                    if (rem_r != '0) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State registers; busy/done are registered from the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            rem_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            rem_r   <= rem_s;
            busy_r  <= (state_s == ST_FETCH) || (state_s == ST_SEND);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;

    cache_reader_pairbuf #(
        .DATA_W(DATA_W)
    ) u_pairbuf (
        .clk      (clk),
        .rst      (rst),
        .load     (fetch_s),
        .load_two (take_two_s),
        .din0     (data_a),
        .din1     (data_b),
        .pop      (pop_s),
        .out_valid(out_valid),
        .out_data (out_data),
        .last_pop (last_pop_s)
    );

`ifdef CACHE_READER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_r;

    // Running modulo-2**DATA_W sum of accepted samples, cleared per burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_r <= '0;
        end else if (start_ok_s) begin
            csum_r <= '0;
        end else if (pop_s) begin
            csum_r <= csum_r + out_data;
        end else begin
            csum_r <= csum_r;
        end
    end

    assign checksum = csum_r;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_cache_reader.sv
// Self-checking bench for cache_reader: table-driven directed bursts, random
// bursts against a queue-based reference model, and reset/abort sequences.
module tb_cache_reader;
    import cache_reader_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int AW = DEF_ADDR_W;
    localparam int CW = DEF_CNT_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] count;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    logic [DW-1:0] cache_mem [8];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          base;
        int          cnt;
        int          rmode;
        bit          poke;
        int          exp_n;
        logic [15:0] exp_first;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    assign data_a = cache_mem[addr_a];
    assign data_b = cache_mem[addr_b];

    cache_reader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .count    (count),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .data_a   (data_a),
        .data_b   (data_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one burst from #1 after a rising edge; the model is the list of
    // cache words base..base+n-1 (mod 8), n = min(count, 8).
    task automatic run_burst(input int b, input int c, input int rmode, input bit poke,
                             output int got, output logic [DW-1:0] first_o);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] exp_sum;
        logic [DW-1:0] exp_ck;
        logic [2:0]    ix;
        int            n;
        int            fetches;
        int            done_cyc;
        int            last_hs;
        int            first_v;
        logic          pv;
        logic          pr;
        logic [DW-1:0] pd;
        logic [AW-1:0] pa;
        logic [AW-1:0] pb;

        n       = (c > 8) ? 8 : c;
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            ix = 3'(b + i);
            exp_q.push_back(cache_mem[ix]);
            exp_sum = exp_sum + cache_mem[ix];
        end
`ifdef CACHE_READER_CHECKSUM_EN
        exp_ck = exp_sum;
`else
        exp_ck = '0;
`endif
        start     = 1'b1;
        base_addr = AW'(b);
        count     = CW'(c);
        @(posedge clk);
        #1;
        start     = 1'b0;
        got       = 0;
        fetches   = 0;
        done_cyc  = -1;
        last_hs   = -1;
        first_v   = -1;
        first_o   = '0;
        pv        = 1'b0;
        pr        = 1'b0;
        pd        = '0;
        pa        = '0;
        pb        = '0;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start     = poke && (n > 0) && (cyc == 2);
            base_addr = AW'($urandom_range(0, 7));
            count     = CW'($urandom_range(1, 15));
            if (out_valid && first_v < 0) first_v = cyc;
            if (out_valid && !pv) begin
                chk("fetch_addr_a", 32'(pa), 32'((b + 2 * fetches) % 8));
                chk("fetch_addr_b", 32'(pb), 32'((b + 2 * fetches + 1) % 8));
                fetches++;
            end
            if (pv && !pr) begin
                chk("stall_valid", 32'(out_valid), 32'(1'b1));
                chk("stall_data", 32'(out_data), 32'(pd));
            end
            if (out_valid && out_ready) begin
                if (got < n) chk("sample", 32'(out_data), 32'(exp_q[got]));
                if (got == 0) first_o = out_data;
                got++;
                last_hs = cyc;
            end
            if (done) begin
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk("done_busy_low", 32'(busy), 32'(1'b0));
                    chk("done_valid_low", 32'(out_valid), 32'(1'b0));
                    chk("checksum", 32'(checksum), 32'(exp_ck));
                end else begin
                    chk("done_single_pulse", cyc, done_cyc);
                end
            end
            if (cyc == 1 && n > 0) chk("busy_after_start", 32'(busy), 32'(1'b1));
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            pa = addr_a;
            pb = addr_b;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        chk("done_seen", 32'(done_cyc >= 0), 32'(1'b1));
        chk("sample_count", got, n);
        if (n == 0) begin
            chk("zero_count_done_cycle", done_cyc, 1);
        end else begin
            chk("first_valid_cycle", first_v, 2);
            chk("done_after_last", done_cyc, last_hs + 1);
        end
    endtask

    initial begin
        int            got;
        logic [DW-1:0] first;

        rst       = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) cache_mem[i] = DW'(16'h1000 + i);

        vecs[0] = '{2, 4, 0, 1'b1, 4, 16'h1002};
        vecs[1] = '{7, 3, 0, 1'b0, 3, 16'h1007};
        vecs[2] = '{0, 8, 1, 1'b0, 8, 16'h1000};
        vecs[3] = '{5, 0, 0, 1'b0, 0, 16'h0000};
        vecs[4] = '{3, 15, 0, 1'b1, 8, 16'h1003};
        vecs[5] = '{6, 1, 1, 1'b0, 1, 16'h1006};
        vecs[6] = '{0, 8, 0, 1'b0, 8, 16'h1000};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
        chk("rst_out_data", 32'(out_data), 32'(16'h0000));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_done", 32'(done), 32'(1'b0));
        chk("rst_checksum", 32'(checksum), 32'(16'h0000));
        chk("rst_addr_a", 32'(addr_a), 32'(3'd0));
        chk("rst_addr_b", 32'(addr_b), 32'(3'd1));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            run_burst(vecs[v].base, vecs[v].cnt, vecs[v].rmode, vecs[v].poke, got, first);
            chk("vec_count", got, vecs[v].exp_n);
            if (vecs[v].exp_n > 0) chk("vec_first", 32'(first), 32'(vecs[v].exp_first));
        end

        // Reset in the third SEND cycle of an 8-sample burst.
        start     = 1'b1;
        base_addr = 3'd0;
        count     = 4'd8;
        @(posedge clk);
        #1;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("abort_pre_valid", 32'(out_valid), 32'(1'b1));
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'(1'b0));
        chk("abort_busy", 32'(busy), 32'(1'b0));
        chk("abort_addr_a", 32'(addr_a), 32'(3'd0));
        chk("abort_addr_b", 32'(addr_b), 32'(3'd1));
        chk("abort_checksum", 32'(checksum), 32'(16'h0000));
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 32'(done), 32'(1'b0));
        end
        rst       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        run_burst(1, 5, 0, 1'b0, got, first);
        chk("post_abort_count", got, 5);

        // Random bursts over random cache contents.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 8; i++) cache_mem[i] = DW'($urandom);
            run_burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), got, first);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
